// File: rtl/lsu_pkg.sv
// Shared LSU types: requester IDs, the request bundle and the arbiter state encoding.
package lsu_pkg;

    localparam int LSU_REQ_ID_W = 1;

    typedef logic [LSU_REQ_ID_W-1:0] lsu_id_t;

    localparam lsu_id_t LSU_ID_CORE = 1'b0;
    localparam lsu_id_t LSU_ID_DBG  = 1'b1;

    typedef struct packed {
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
    } lsu_req_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // A request is live on either strobe; a write takes precedence over a read.
    function automatic logic req_active(input lsu_req_t r);
        return r.rd | (|r.wr);
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// Bundle of both requester ports, both response ports and the shared data-memory port.
interface lsu_mem_arbiter_if;

    logic        req0_rd_i;
    logic [3:0]  req0_wr_i;
    logic [31:0] req0_addr_i;
    logic [31:0] req0_data_i;
    logic        req0_accept_o;
    logic        req1_rd_i;
    logic [3:0]  req1_wr_i;
    logic [31:0] req1_addr_i;
    logic [31:0] req1_data_i;
    logic        req1_accept_o;

    logic        resp0_ack_o;
    logic        resp0_error_o;
    logic        resp1_ack_o;
    logic        resp1_error_o;
    logic [31:0] resp_data_o;

    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_wr_o;
    logic        mem_accept_i;
    logic        mem_ack_i;
    logic        mem_error_i;
    logic [31:0] mem_data_rd_i;

    logic        spurious_o;

    modport slave (
        input  req0_rd_i, req0_wr_i, req0_addr_i, req0_data_i,
        input  req1_rd_i, req1_wr_i, req1_addr_i, req1_data_i,
        output req0_accept_o, req1_accept_o,
        output resp0_ack_o, resp0_error_o, resp1_ack_o, resp1_error_o, resp_data_o,
        output mem_rd_o, mem_wr_o, mem_addr_o, mem_data_wr_o,
        input  mem_accept_i, mem_ack_i, mem_error_i, mem_data_rd_i,
        output spurious_o
    );

    modport master (
        output req0_rd_i, req0_wr_i, req0_addr_i, req0_data_i,
        output req1_rd_i, req1_wr_i, req1_addr_i, req1_data_i,
        input  req0_accept_o, req1_accept_o,
        input  resp0_ack_o, resp0_error_o, resp1_ack_o, resp1_error_o, resp_data_o,
        input  mem_rd_o, mem_wr_o, mem_addr_o, mem_data_wr_o,
        output mem_accept_i, mem_ack_i, mem_error_i, mem_data_rd_i,
        input  spurious_o
    );

endinterface

// File: rtl/lsu_tag_fifo.sv
// In-order FIFO of requester IDs for requests issued to memory but not yet acknowledged.
module lsu_tag_fifo #(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             accept_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              do_push;
    logic              do_pop;

    // Full/empty come from the registered count only, so a same-cycle pop never frees a slot early.
    assign accept_o   = (count_q != (ADDR_W+1)'(DEPTH));
    assign valid_o    = (count_q != '0);
    assign do_push    = push_i & accept_o;
    assign do_pop     = pop_i & valid_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU and the CSR/debug requester,
// with the grant locked until memory accepts and responses routed back in issue order.
module lsu_mem_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int TAG_ADDR_W  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    lsu_mem_arbiter_if.slave bus
);

    import lsu_pkg::*;

    arb_state_e state_q, state_d;
    lsu_id_t    last_grant_q, last_grant_d;
    lsu_id_t    lock_id_q, lock_id_d;
    lsu_id_t    grant_id;
    lsu_id_t    fifo_head;
    lsu_req_t   req0, req1, sel_req;
    logic       active0, active1;
    logic       have_grant, issue, done;
    logic       fifo_can_push, fifo_valid, ack_valid;
    logic       spurious_q;

    assign req0 = '{rd: bus.req0_rd_i, wr: bus.req0_wr_i, addr: bus.req0_addr_i, data: bus.req0_data_i};
    assign req1 = '{rd: bus.req1_rd_i, wr: bus.req1_wr_i, addr: bus.req1_addr_i, data: bus.req1_data_i};
    assign active0 = req_active(req0);
    assign active1 = req_active(req1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= LSU_ID_DBG;
            lock_id_q    <= LSU_ID_CORE;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_id_q    <= lock_id_d;
            spurious_q   <= spurious_q | (bus.mem_ack_i & ~fifo_valid);
        end
    end

    // Any pick that does not complete this cycle (memory stall or full tag FIFO) locks the grant.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_id_d    = lock_id_q;
        have_grant   = 1'b0;
        grant_id     = lock_id_q;
        case (state_q)
            ARB_IDLE: begin
                if (active0 | active1) begin
                    have_grant = 1'b1;
                    if (active0 & active1) begin
                        grant_id = ~last_grant_q;
                    end else begin
                        grant_id = active1 ? LSU_ID_DBG : LSU_ID_CORE;
                    end
                    last_grant_d = grant_id;
                end
            end
            ARB_LOCKED: begin
                have_grant = 1'b1;
            end
            default: begin
                have_grant = 1'b0;
            end
        endcase
        issue = have_grant & fifo_can_push & ~rst_i;
        done  = issue & bus.mem_accept_i;
        if (done) begin
            state_d = ARB_IDLE;
        end else if (have_grant) begin
            state_d   = ARB_LOCKED;
            lock_id_d = grant_id;
        end
    end

    assign sel_req = (grant_id == LSU_ID_DBG) ? req1 : req0;

    assign bus.mem_rd_o      = issue & sel_req.rd & ~(|sel_req.wr);
    assign bus.mem_wr_o      = issue ? sel_req.wr : 4'b0000;
    assign bus.mem_addr_o    = issue ? sel_req.addr : 32'h0;
    assign bus.mem_data_wr_o = issue ? sel_req.data : 32'h0;
    assign bus.req0_accept_o = done & (grant_id == LSU_ID_CORE);
    assign bus.req1_accept_o = done & (grant_id == LSU_ID_DBG);

    lsu_tag_fifo #(
        .WIDTH  (LSU_REQ_ID_W),
        .DEPTH  (OUTSTANDING),
        .ADDR_W (TAG_ADDR_W)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (done),
        .push_data_i (grant_id),
        .accept_o    (fifo_can_push),
        .pop_i       (ack_valid),
        .pop_data_o  (fifo_head),
        .valid_o     (fifo_valid)
    );

    // Acks with nothing outstanding are dropped here and only recorded in the sticky flag.
    assign ack_valid         = bus.mem_ack_i & fifo_valid & ~rst_i;
    assign bus.resp0_ack_o   = ack_valid & (fifo_head == LSU_ID_CORE);
    assign bus.resp1_ack_o   = ack_valid & (fifo_head == LSU_ID_DBG);
    assign bus.resp0_error_o = bus.resp0_ack_o & bus.mem_error_i;
    assign bus.resp1_error_o = bus.resp1_ack_o & bus.mem_error_i;
    assign bus.resp_data_o   = rst_i ? 32'h0 : bus.mem_data_rd_i;
    assign bus.spurious_o    = spurious_q;

endmodule
